// File: rtl/lsu.sv
// Load/store unit: byte-addressable data memory plus memory-mapped LED, HEX, LCD
// and switch registers. Loads are combinational; stores commit on the rising clock.
module lsu #(
  parameter int unsigned DMEM_BYTES = 16384
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_lsu_addr,
  input  logic [31:0] i_st_data,
  input  logic [1:0]  i_lsu_size,
  input  logic        i_lsu_signed,
  input  logic        i_lsu_wren,
  output logic [31:0] o_ld_data,
  output logic [31:0] o_io_ledr,
  output logic [31:0] o_io_ledg,
  output logic [6:0]  o_io_hex [0:7],
  output logic [31:0] o_io_lcd,
  input  logic [31:0] i_io_sw
);

  localparam int unsigned AW = $clog2(DMEM_BYTES);

  typedef enum logic [2:0] {
    R_NONE, R_DMEM, R_LEDR, R_LEDG, R_HEX0, R_HEX1, R_LCD, R_SW
  } region_e;

  region_e      region;
  logic [2:0]   nbytes;
  logic [1:0]   lane;
  logic [AW-1:0] maddr [4];
  logic [31:0]  raw;

  logic [7:0]   mem [DMEM_BYTES];

  logic [31:0]  ledr_q, ledr_d;
  logic [31:0]  ledg_q, ledg_d;
  logic [31:0]  hex03_q, hex03_d;
  logic [31:0]  hex47_q, hex47_d;
  logic [31:0]  lcd_q, lcd_d;

  // IO registers are addressed by byte lane; bytes that would spill past lane 3 are dropped.
  function automatic logic [31:0] io_merge(input logic [31:0] old, input logic [31:0] data,
                                           input logic [1:0] ln, input logic [2:0] nb);
    logic [31:0] res;
    res = old;
    for (int unsigned k = 0; k < 4; k++) begin
      if (k < 32'(nb) && 32'(ln) + k < 4)
        res[8*(32'(ln)+k) +: 8] = data[8*k +: 8];
    end
    return res;
  endfunction

  function automatic logic [31:0] io_extract(input logic [31:0] r, input logic [1:0] ln);
    logic [31:0] res;
    res = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      if (32'(ln) + k < 4)
        res[8*k +: 8] = r[8*(32'(ln)+k) +: 8];
    end
    return res;
  endfunction

  always_comb begin
    region = R_NONE;
    if (i_lsu_addr < 32'(DMEM_BYTES)) begin
      region = R_DMEM;
    end else begin
      case (i_lsu_addr[31:12])
        20'h10000: region = R_LEDR;
        20'h10001: region = R_LEDG;
        20'h10002: region = R_HEX0;
        20'h10003: region = R_HEX1;
        20'h10004: region = R_LCD;
        20'h10010: region = R_SW;
        default:   region = R_NONE;
      endcase
    end
  end

  always_comb begin
    case (i_lsu_size)
      2'b00:   nbytes = 3'd1;
      2'b01:   nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
    lane = i_lsu_addr[1:0];
    for (int unsigned k = 0; k < 4; k++)
      maddr[k] = i_lsu_addr[AW-1:0] + AW'(k);
  end

  // Memory wraps modulo its size so misaligned accesses never need a second cycle.
  always_ff @(posedge i_clk) begin
    if (!i_reset && i_lsu_wren && region == R_DMEM) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (k < 32'(nbytes))
          mem[maddr[k]] <= i_st_data[8*k +: 8];
      end
    end
  end

  always_comb begin
    ledr_d  = ledr_q;
    ledg_d  = ledg_q;
    hex03_d = hex03_q;
    hex47_d = hex47_q;
    lcd_d   = lcd_q;
    if (i_lsu_wren) begin
      case (region)
        R_LEDR: ledr_d  = io_merge(ledr_q, i_st_data, lane, nbytes);
        R_LEDG: ledg_d  = io_merge(ledg_q, i_st_data, lane, nbytes);
        R_HEX0: hex03_d = io_merge(hex03_q, i_st_data, lane, nbytes) & 32'h7F7F_7F7F;
        R_HEX1: hex47_d = io_merge(hex47_q, i_st_data, lane, nbytes) & 32'h7F7F_7F7F;
        R_LCD:  lcd_d   = io_merge(lcd_q, i_st_data, lane, nbytes);
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ledr_q  <= '0;
      ledg_q  <= '0;
      hex03_q <= '0;
      hex47_q <= '0;
      lcd_q   <= '0;
    end else begin
      ledr_q  <= ledr_d;
      ledg_q  <= ledg_d;
      hex03_q <= hex03_d;
      hex47_q <= hex47_d;
      lcd_q   <= lcd_d;
    end
  end

  always_comb begin
    raw = '0;
    case (region)
      R_DMEM: for (int unsigned k = 0; k < 4; k++) raw[8*k +: 8] = mem[maddr[k]];
      R_LEDR: raw = io_extract(ledr_q, lane);
      R_LEDG: raw = io_extract(ledg_q, lane);
      R_HEX0: raw = io_extract(hex03_q, lane);
      R_HEX1: raw = io_extract(hex47_q, lane);
      R_LCD:  raw = io_extract(lcd_q, lane);
      R_SW:   raw = io_extract(i_io_sw, lane);
      default: raw = '0;
    endcase
  end

  always_comb begin
    case (i_lsu_size)
      2'b00:   o_ld_data = {{24{i_lsu_signed & raw[7]}}, raw[7:0]};
      2'b01:   o_ld_data = {{16{i_lsu_signed & raw[15]}}, raw[15:0]};
      default: o_ld_data = raw;
    endcase
  end

  always_comb begin
    for (int unsigned n = 0; n < 4; n++) begin
      o_io_hex[n]   = hex03_q[8*n +: 7];
      o_io_hex[n+4] = hex47_q[8*n +: 7];
    end
  end

  assign o_io_ledr = ledr_q;
  assign o_io_ledg = ledg_q;
  assign o_io_lcd  = lcd_q;

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu: memory alignment/extension, IO lanes,
// switches, unmapped addresses and reset behaviour.
module tb_lsu;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] st_data;
  logic [1:0]  size;
  logic        sgn;
  logic        wren;
  logic [31:0] ld_data;
  logic [31:0] ledr, ledg, lcd;
  logic [6:0]  hex [0:7];
  logic [31:0] sw;

  int n_cmp = 0;
  int n_err = 0;

  lsu #(.DMEM_BYTES(16384)) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_lsu_addr  (addr),
    .i_st_data   (st_data),
    .i_lsu_size  (size),
    .i_lsu_signed(sgn),
    .i_lsu_wren  (wren),
    .o_ld_data   (ld_data),
    .o_io_ledr   (ledr),
    .o_io_ledg   (ledg),
    .o_io_hex    (hex),
    .o_io_lcd    (lcd),
    .i_io_sw     (sw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    @(negedge clk);
    addr = a; st_data = d; size = sz; sgn = 1'b0; wren = 1'b1;
    @(posedge clk);
    #1;
    wren = 1'b0;
  endtask

  task automatic load(input string tag, input logic [31:0] a, input logic [1:0] sz,
                      input logic s, input logic [31:0] exp);
    @(negedge clk);
    addr = a; size = sz; sgn = s; wren = 1'b0;
    #1;
    check(tag, ld_data, exp);
  endtask

  task automatic check_io_zero(input string tag);
    check({tag, "_ledr"}, ledr, 32'h0);
    check({tag, "_ledg"}, ledg, 32'h0);
    check({tag, "_lcd"}, lcd, 32'h0);
    for (int i = 0; i < 8; i++)
      check($sformatf("%s_hex%0d", tag, i), 32'(hex[i]), 32'h0);
  endtask

  initial begin
    rst = 1'b1; addr = '0; st_data = '0; size = 2'b10; sgn = 1'b0; wren = 1'b0; sw = '0;
    repeat (2) @(posedge clk);
    #1;
    check_io_zero("reset");
    rst = 1'b0;

    // aligned word / halfword
    store(32'h0, 32'h8484_D609, 2'b10);
    load("ldw0", 32'h0, 2'b10, 1'b0, 32'h8484_D609);
    load("ldh2s", 32'h2, 2'b01, 1'b1, 32'hFFFF_8484);
    load("ldh2u", 32'h2, 2'b01, 1'b0, 32'h0000_8484);
    load("ldb0u", 32'h0, 2'b00, 1'b0, 32'h0000_0009);
    load("ldb3s", 32'h3, 2'b00, 1'b1, 32'hFFFF_FF84);
    load("ldsz3", 32'h0, 2'b11, 1'b1, 32'h8484_D609);

    // byte store
    store(32'd60, 32'hFFFF_FF81, 2'b00);
    load("ldb60s", 32'd60, 2'b00, 1'b1, 32'hFFFF_FF81);
    load("ldb60u", 32'd60, 2'b00, 1'b0, 32'h0000_0081);

    // misaligned
    store(32'd121, 32'h1234_BEEF, 2'b01);
    load("ldb121", 32'd121, 2'b00, 1'b0, 32'h0000_00EF);
    load("ldb122", 32'd122, 2'b00, 1'b0, 32'h0000_00BE);
    store(32'd120, 32'h0000_0011, 2'b00);
    store(32'd123, 32'h0000_0022, 2'b00);
    load("ldw120", 32'd120, 2'b10, 1'b0, 32'h22BE_EF11);
    load("ldh121s", 32'd121, 2'b01, 1'b1, 32'hFFFF_BEEF);

    // wrap-around at end of memory
    store(32'd16382, 32'hA1B2_C3D4, 2'b10);
    load("ldwwrap", 32'd16382, 2'b10, 1'b0, 32'hA1B2_C3D4);
    load("ldh0", 32'h0, 2'b01, 1'b0, 32'h0000_A1B2);
    load("ldw0b", 32'h0, 2'b10, 1'b0, 32'h8484_A1B2);

    // IO registers
    store(32'h1000_0000, 32'h1234_5678, 2'b10);
    check("ledr", ledr, 32'h1234_5678);
    load("ldledr", 32'h1000_0000, 2'b10, 1'b0, 32'h1234_5678);
    store(32'h1000_2000, 32'h7F3F_0640, 2'b10);
    check("hex0", 32'(hex[0]), 32'h40);
    check("hex1", 32'(hex[1]), 32'h06);
    check("hex2", 32'(hex[2]), 32'h3F);
    check("hex3", 32'(hex[3]), 32'h7F);
    store(32'h1000_3000, 32'hFFFF_FFFF, 2'b10);
    check("hex4", 32'(hex[4]), 32'h7F);
    check("hex7", 32'(hex[7]), 32'h7F);
    load("ldhex47", 32'h1000_3000, 2'b10, 1'b0, 32'h7F7F_7F7F);
    store(32'h1000_1002, 32'h0000_00AB, 2'b00);
    check("ledg_b2", ledg, 32'h00AB_0000);
    store(32'h1000_1003, 32'h0000_CDEF, 2'b01);
    check("ledg_h3", ledg, 32'hEFAB_0000);
    load("ldledg_h3", 32'h1000_1003, 2'b01, 1'b0, 32'h0000_00EF);
    load("ldledg_b3s", 32'h1000_1003, 2'b00, 1'b1, 32'hFFFF_FFEF);
    load("ldledg_w1", 32'h1000_1001, 2'b10, 1'b0, 32'h00EF_AB00);
    store(32'h1000_4000, 32'h0BAD_F00D, 2'b10);
    check("lcd", lcd, 32'h0BAD_F00D);

    // switches
    sw = 32'hDEAD_BEEF;
    load("ldsw", 32'h1001_0000, 2'b10, 1'b0, 32'hDEAD_BEEF);
    load("ldsw_b1", 32'h1001_0001, 2'b00, 1'b0, 32'h0000_00BE);
    store(32'h1001_0000, 32'h5555_5555, 2'b10);
    check("sw_st_ledr", ledr, 32'h1234_5678);
    check("sw_st_lcd", lcd, 32'h0BAD_F00D);
    load("sw_st_mem", 32'h0, 2'b10, 1'b0, 32'h8484_A1B2);
    load("ldsw2", 32'h1001_0000, 2'b10, 1'b0, 32'hDEAD_BEEF);

    // unmapped
    load("ldunm", 32'h2000_0000, 2'b10, 1'b0, 32'h0);
    load("ldunm_io", 32'h1000_5000, 2'b10, 1'b0, 32'h0);
    load("ldunm_top", 32'h0000_4000, 2'b10, 1'b0, 32'h0);
    store(32'h2000_0000, 32'hFFFF_FFFF, 2'b10);
    store(32'h0000_4000, 32'h9999_9999, 2'b10);
    check("unm_ledr", ledr, 32'h1234_5678);
    check("unm_ledg", ledg, 32'hEFAB_0000);
    load("unm_mem", 32'h0, 2'b10, 1'b0, 32'h8484_A1B2);

    // reset discards the concurrent store and clears IO
    store(32'd200, 32'h1111_1111, 2'b10);
    @(negedge clk);
    rst = 1'b1; addr = 32'd200; st_data = 32'h2222_2222; size = 2'b10; wren = 1'b1;
    @(posedge clk);
    #1;
    wren = 1'b0; rst = 1'b0;
    check_io_zero("midrst");
    load("rst_mem", 32'd200, 2'b10, 1'b0, 32'h1111_1111);
    load("rst_mem0", 32'h0, 2'b10, 1'b0, 32'h8484_A1B2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
